// File: rtl/timetag_pkg.sv
// rtl/timetag_pkg.sv - shared timetag record constants and types
package timetag_pkg;

    localparam int TT_DEFAULT_REC_BYTES = 16;

    // Records leave byte 0 (bits 7:0) first.
    localparam bit TT_REC_LITTLE_ENDIAN = 1'b1;

    // host_iface output multiplexer channel assignments
    localparam int unsigned OMUX_CH_STATUS  = 0;
    localparam int unsigned OMUX_CH_RECORDS = 1;
    localparam int unsigned OMUX_CH_COUNT   = 2;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_t;

endpackage

// File: rtl/record_serializer.sv
// rtl/record_serializer.sv - byte index and byte/last selection for the head record
module record_serializer
    import timetag_pkg::*;
#(
    parameter int REC_BYTES = TT_DEFAULT_REC_BYTES
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [8*REC_BYTES-1:0] head_i,
    input  logic                   empty_i,
    input  logic                   adv_i,
    output logic [7:0]             data_o,
    output logic                   last_o,
    output logic                   pop_o
);

    localparam int BIDX_W = $clog2(REC_BYTES);
    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(REC_BYTES - 1);

    logic [BIDX_W-1:0]      bidx;
    logic [BIDX_W-1:0]      byte_sel;
    logic [8*REC_BYTES-1:0] shifted;
    logic                   at_last;

    assign at_last  = (bidx == LAST_IDX);
    assign byte_sel = TT_REC_LITTLE_ENDIAN ? bidx : (LAST_IDX - bidx);
    assign shifted  = head_i >> {byte_sel, 3'b000};

    assign data_o = empty_i ? 8'h00 : shifted[7:0];
    assign last_o = !empty_i && at_last;
    assign pop_o  = adv_i && at_last;

    // bidx is held while the grant is away so the stream resumes on the same byte.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bidx <= '0;
        end else if (adv_i) begin
            bidx <= at_last ? '0 : bidx + 1'b1;
        end
    end

endmodule

// File: rtl/record_fifo.sv
// rtl/record_fifo.sv - multi-record timetag queue streaming bytes to one omux channel (optional RECORD_FIFO_DROP_COUNT_EN)
module record_fifo
    import timetag_pkg::*;
#(
    parameter int REC_BYTES  = TT_DEFAULT_REC_BYTES,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [8*REC_BYTES-1:0] rec_i,
    input  logic                   we_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [DEPTH_LOG2:0]    level_o,
    output logic                   omux_req_o,
    input  logic                   omux_sel_i,
    input  logic                   omux_ack_i,
    output logic [7:0]             omux_data_o,
    output logic                   omux_last_o
`ifdef RECORD_FIFO_DROP_COUNT_EN
    ,
    output logic [31:0]            drop_count_o
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [8*REC_BYTES-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    level;
    logic [DEPTH_LOG2:0]    level_next;
    logic                   full;
    logic                   empty;
    logic                   adv;
    logic                   pop;
    logic                   push;
    rd_state_t              state;
    rd_state_t              state_next;

    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);
    assign adv   = omux_sel_i && omux_ack_i && !empty;
    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign push  = we_i && (!full || pop);

    assign full_o  = full;
    assign empty_o = empty;
    assign level_o = level;

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + 1'b1;
        end else if (pop && !push) begin
            level_next = level - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= rec_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        omux_req_o = 1'b0;
        case (state)
            RD_IDLE: begin
                if (level_next != '0) begin
                    state_next = RD_STREAM;
                end
            end
            RD_STREAM: begin
                omux_req_o = 1'b1;
                if (level_next == '0) begin
                    state_next = RD_IDLE;
                end
            end
            default: state_next = RD_IDLE;
        endcase
    end

    record_serializer #(
        .REC_BYTES(REC_BYTES)
    ) u_serializer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .head_i  (mem[rd_ptr]),
        .empty_i (empty),
        .adv_i   (adv),
        .data_o  (omux_data_o),
        .last_o  (omux_last_o),
        .pop_o   (pop)
    );

`ifdef RECORD_FIFO_DROP_COUNT_EN
    logic        drop;
    logic [31:0] drop_count;

    assign drop         = we_i && full && !pop;
    assign drop_count_o = drop_count;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 32'hFFFF_FFFF)) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`endif

endmodule
